mips_regfile_param: RTL and testbench



---
 rtl/mips_pkg.sv | 15 +
 rtl/mips_reg_scoreboard.sv | 45 ++++
 rtl/mips_regfile_param.sv | 81 ++++++++
 tb/tb_mips_regfile_param.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS register file family.
//   MIPS_WIDTH  - default data width of one register
//   MIPS_DEPTH  - default number of architectural registers
//   REG_ZERO    - index of the hardwired-zero register
//   reg_addr_t  - 5-bit register index of the classic 32-entry file
package mips_pkg;

  localparam int MIPS_WIDTH = 32;
  localparam int MIPS_DEPTH = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef logic [4:0] reg_addr_t;

endpackage

// File: rtl/mips_reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
//   clk, rst_n   - clock, asynchronous active-low clear of every bit
//   clr_en/reg   - writeback retires the pending producer of clr_reg
//   set_en/reg   - decode issues a new producer for set_reg
//   busy_vec     - registered busy bits; bit 0 is always 0
// A set and a clear on the same register in the same cycle leave the bit
// set: the set belongs to a younger producer that is still in flight.
module mips_reg_scoreboard
  import mips_pkg::*;
#(
  parameter int DEPTH  = MIPS_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_reg,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_reg,
  output logic [DEPTH-1:0]  busy_vec
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_nxt;

  always_comb begin
    busy_nxt = '0;
    // Register 0 can never have a pending producer.
    for (int i = 1; i < DEPTH; i++) begin
      busy_nxt[i] = (set_en && (set_reg == ADDR_W'(i))) ||
                    (busy_q[i] && !(clr_en && (clr_reg == ADDR_W'(i))));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/mips_regfile_param.sv
// Parametrised MIPS register file with write-to-read bypass and a
// pending-write scoreboard.
//   clk, rst_n        - clock, asynchronous active-low reset
//   read_reg          - NUM_READ packed read addresses (port i at i*ADDR_W)
//   read_data         - NUM_READ packed read data (port i at i*WIDTH)
//   read_busy         - per port: addressed register has a pending write
//   signal_reg_write  - writeback enable, write_reg / write_data its payload
//   mark_busy         - decode marks mark_reg as pending
//   busy_vec          - full scoreboard for stall logic and debug
// Register 0 reads as zero and ignores writes and marks.
module mips_regfile_param
  import mips_pkg::*;
#(
  parameter int WIDTH    = MIPS_WIDTH,
  parameter int DEPTH    = MIPS_DEPTH,
  parameter int NUM_READ = 2,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_READ*ADDR_W-1:0]   read_reg,
  output logic [NUM_READ*WIDTH-1:0]    read_data,
  output logic [NUM_READ-1:0]          read_busy,
  input  logic                         signal_reg_write,
  input  logic [ADDR_W-1:0]            write_reg,
  input  logic [WIDTH-1:0]             write_data,
  input  logic                         mark_busy,
  input  logic [ADDR_W-1:0]            mark_reg,
  output logic [DEPTH-1:0]             busy_vec
);

  logic [WIDTH-1:0] regs [DEPTH];

  // A writeback that actually lands. Qualifying it with rst_n keeps the
  // bypass path from leaking write_data onto the read ports while the
  // file is being held in reset.
  logic wr_hit;
  logic mark_hit;

  assign wr_hit   = rst_n && signal_reg_write && (write_reg != ADDR_W'(REG_ZERO));
  assign mark_hit = mark_busy && (mark_reg != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_hit) begin
      regs[write_reg] <= write_data;
    end
  end

  mips_reg_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_en   (wr_hit),
    .clr_reg  (write_reg),
    .set_en   (mark_hit),
    .set_reg  (mark_reg),
    .busy_vec (busy_vec)
  );

  // Read ports are independent combinational muxes. Register 0 is never
  // written and is cleared by reset, so the plain array read returns 0.
  for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              byp;

    assign addr = read_reg[g*ADDR_W +: ADDR_W];
    assign byp  = (BYPASS != 0) && wr_hit && (write_reg == addr);

    assign read_data[g*WIDTH +: WIDTH] = byp ? write_data : regs[addr];
    // Data delivered by bypass this cycle means the hazard is resolved now.
    assign read_busy[g] = byp ? 1'b0 : busy_vec[addr];
  end

endmodule

// File: tb/tb_mips_regfile_param.sv
module tb_mips_regfile_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // DUT A (BYPASS=1) and DUT B (BYPASS=0) share one stimulus set.
  logic [9:0]  read_reg;
  logic        we;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic        mark;
  logic [4:0]  mreg;
  logic [63:0] a_rd, b_rd;
  logic [1:0]  a_rb, b_rb;
  logic [31:0] a_bv, b_bv;

  // DUT C: WIDTH=16, DEPTH=8, NUM_READ=3.
  logic [8:0]  c_rreg;
  logic        c_we;
  logic [2:0]  c_wreg;
  logic [15:0] c_wdata;
  logic        c_mark;
  logic [2:0]  c_mreg;
  logic [47:0] c_rd;
  logic [2:0]  c_rb;
  logic [7:0]  c_bv;

  mips_regfile_param #(.WIDTH(32), .DEPTH(32), .NUM_READ(2), .BYPASS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .read_reg(read_reg), .read_data(a_rd),
    .read_busy(a_rb), .signal_reg_write(we), .write_reg(wreg),
    .write_data(wdata), .mark_busy(mark), .mark_reg(mreg), .busy_vec(a_bv)
  );

  mips_regfile_param #(.WIDTH(32), .DEPTH(32), .NUM_READ(2), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .read_reg(read_reg), .read_data(b_rd),
    .read_busy(b_rb), .signal_reg_write(we), .write_reg(wreg),
    .write_data(wdata), .mark_busy(mark), .mark_reg(mreg), .busy_vec(b_bv)
  );

  mips_regfile_param #(.WIDTH(16), .DEPTH(8), .NUM_READ(3), .BYPASS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .read_reg(c_rreg), .read_data(c_rd),
    .read_busy(c_rb), .signal_reg_write(c_we), .write_reg(c_wreg),
    .write_data(c_wdata), .mark_busy(c_mark), .mark_reg(c_mreg), .busy_vec(c_bv)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    string       tag;
    int          dut;
    logic [95:0] data;
    logic [2:0]  rbusy;
    logic [31:0] bvec;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic push(input string tag, input int dut, input logic [95:0] d,
                      input logic [2:0] rb, input logic [31:0] bv);
    exp_t e;
    e.tag = tag; e.dut = dut; e.data = d; e.rbusy = rb; e.bvec = bv;
    exp_q.push_back(e);
  endtask

  task automatic push_ab(input string tag,
                         input logic [63:0] da, input logic [1:0] ra,
                         input logic [63:0] db, input logic [1:0] rb,
                         input logic [31:0] bv);
    push({tag, "_a"}, 0, {32'h0, da}, {1'b0, ra}, bv);
    push({tag, "_b"}, 1, {32'h0, db}, {1'b0, rb}, bv);
  endtask

  task automatic check(input string tag, input string what,
                       input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", tag, what, act, exp);
    end
  endtask

  // Monitor: the register file presents its outputs combinationally every
  // cycle; each queued expectation is compared on the falling edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [95:0] ad;
    logic [2:0]  ar;
    logic [31:0] ab;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.dut)
        0:       begin ad = {32'h0, a_rd}; ar = {1'b0, a_rb}; ab = a_bv; end
        1:       begin ad = {32'h0, b_rd}; ar = {1'b0, b_rb}; ab = b_bv; end
        default: begin ad = {48'h0, c_rd}; ar = c_rb; ab = {24'h0, c_bv}; end
      endcase
      check(e.tag, "read_data", ad, e.data);
      check(e.tag, "read_busy", {93'h0, ar}, {93'h0, e.rbusy});
      check(e.tag, "busy_vec", {64'h0, ab}, {64'h0, e.bvec});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; mark = 1'b0; c_we = 1'b0; c_mark = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    read_reg = {5'd3, 5'd3};
    we = 1'b1; wreg = 5'd3; wdata = 32'hAAAA_AAAA;
    mark = 1'b1; mreg = 5'd3;
    c_rreg = {3'd3, 3'd3, 3'd3};
    c_we = 1'b1; c_wreg = 3'd3; c_wdata = 16'hAAAA;
    c_mark = 1'b1; c_mreg = 3'd3;

    // Held in reset with a write and mark asserted: everything stays 0.
    cyc(); cyc();
    push_ab("reset", 64'h0, 2'b00, 64'h0, 2'b00, 32'h0);
    push("reset_c", 2, 96'h0, 3'b000, 32'h0);

    // Release between edges and read register 3.
    cyc();
    rst_n = 1'b1; idle();
    push_ab("rel_rd3", 64'h0, 2'b00, 64'h0, 2'b00, 32'h0);
    cyc();
    push_ab("rd3_after_edge", 64'h0, 2'b00, 64'h0, 2'b00, 32'h0);

    // Write 0x55555555 to register 5 while reading register 0.
    cyc();
    we = 1'b1; wreg = 5'd5; wdata = 32'h5555_5555; read_reg = {5'd0, 5'd0};
    push_ab("wr5", 64'h0, 2'b00, 64'h0, 2'b00, 32'h0);
    // Write to register 0 while reading 5 on port 0 and 0 on port 1.
    cyc();
    wreg = 5'd0; wdata = 32'hFFFF_FFFF; read_reg = {5'd0, 5'd5};
    push_ab("wr0", {32'h0, 32'h5555_5555}, 2'b00,
                   {32'h0, 32'h5555_5555}, 2'b00, 32'h0);
    cyc();
    we = 1'b0; read_reg = {5'd5, 5'd5};
    push_ab("rd5_both", {2{32'h5555_5555}}, 2'b00,
                        {2{32'h5555_5555}}, 2'b00, 32'h0);
    // Register 0 stays 0 after the write; a mark of register 0 is issued.
    cyc();
    read_reg = {5'd0, 5'd0}; mark = 1'b1; mreg = 5'd0;
    push_ab("rd0", 64'h0, 2'b00, 64'h0, 2'b00, 32'h0);

    // Bypass: mark 7, then write 7 with port 0 reading 7.
    cyc();
    mark = 1'b1; mreg = 5'd7; read_reg = {5'd5, 5'd7};
    push_ab("mark7", {32'h5555_5555, 32'h0}, 2'b00,
                     {32'h5555_5555, 32'h0}, 2'b00, 32'h0);
    cyc();
    mark = 1'b0; we = 1'b1; wreg = 5'd7; wdata = 32'h1234_5678;
    push_ab("bypass7", {32'h5555_5555, 32'h1234_5678}, 2'b00,
                       {32'h5555_5555, 32'h0}, 2'b01, 32'h0000_0080);
    cyc();
    we = 1'b0; read_reg = {5'd7, 5'd7};
    push_ab("rd7", {2{32'h1234_5678}}, 2'b00,
                   {2{32'h1234_5678}}, 2'b00, 32'h0);

    // Scoreboard on register 9.
    cyc();
    mark = 1'b1; mreg = 5'd9; read_reg = {5'd9, 5'd9};
    push_ab("mark9", 64'h0, 2'b00, 64'h0, 2'b00, 32'h0);
    cyc();
    we = 1'b1; wreg = 5'd9; wdata = 32'h0000_0099;
    push_ab("wr_mark9", {2{32'h0000_0099}}, 2'b00,
                        64'h0, 2'b11, 32'h0000_0200);
    cyc();
    mark = 1'b0; wdata = 32'h0000_009A;
    push_ab("wr9_lone", {2{32'h0000_009A}}, 2'b00,
                        {2{32'h0000_0099}}, 2'b11, 32'h0000_0200);
    cyc();
    we = 1'b0;
    push_ab("clr9", {2{32'h0000_009A}}, 2'b00,
                    {2{32'h0000_009A}}, 2'b00, 32'h0);

    // Fill registers 1..4 with data and pending marks.
    for (int k = 1; k <= 4; k++) begin
      cyc();
      we = 1'b1; wreg = 5'(k); wdata = 32'h1111_1111 * 32'(k);
      mark = 1'b1; mreg = 5'(k); read_reg = {5'd4, 5'd1};
    end
    cyc();
    idle();
    push_ab("filled", {32'h4444_4444, 32'h1111_1111}, 2'b11,
                      {32'h4444_4444, 32'h1111_1111}, 2'b11, 32'h0000_001E);

    // Reset pulse between edges with a write to 4 and a mark of 3 pending.
    cyc();
    we = 1'b1; wreg = 5'd4; wdata = 32'hDEAD_BEEF; mark = 1'b1; mreg = 5'd3;
    #1 rst_n = 1'b0;
    push_ab("midreset", 64'h0, 2'b00, 64'h0, 2'b00, 32'h0);
    #5 rst_n = 1'b1;
    idle();
    cyc();
    push_ab("post_reset", 64'h0, 2'b00, 64'h0, 2'b00, 32'h0);

    // Parameter sweep on DUT C: distinct values in registers 1..7.
    for (int k = 1; k <= 7; k++) begin
      cyc();
      c_we = 1'b1; c_wreg = 3'(k); c_wdata = 16'h1111 * 16'(k);
    end
    cyc();
    c_we = 1'b0; c_rreg = {3'd7, 3'd6, 3'd5};
    push("c_765", 2, {48'h0, 16'h7777, 16'h6666, 16'h5555}, 3'b000, 32'h0);
    cyc();
    c_rreg = {3'd1, 3'd2, 3'd3};
    push("c_123", 2, {48'h0, 16'h1111, 16'h2222, 16'h3333}, 3'b000, 32'h0);
    cyc();
    c_rreg = {3'd4, 3'd0, 3'd1};
    push("c_401", 2, {48'h0, 16'h4444, 16'h0000, 16'h1111}, 3'b000, 32'h0);
    cyc();
    c_we = 1'b1; c_wreg = 3'd2; c_wdata = 16'hBEEF;
    c_mark = 1'b1; c_mreg = 3'd5; c_rreg = {3'd2, 3'd5, 3'd2};
    push("c_bypass", 2, {48'h0, 16'hBEEF, 16'h5555, 16'hBEEF}, 3'b000, 32'h0);
    cyc();
    c_we = 1'b0; c_mark = 1'b0;
    push("c_busy5", 2, {48'h0, 16'hBEEF, 16'h5555, 16'hBEEF}, 3'b010, 32'h0000_0020);

    // ---------------- final report ----------------
    cyc(); cyc();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
